matmul_result_streamer: RTL and testbench

Reads the result matrix produced by `matmul` and serialises it as a row-major stream of signed elements over a valid/ready handshake. The block sits on the output side of `matmul`, converting the parallel `outmat` array into one element per cycle for a narrow consumer such as a FIFO, DMA, or bench scoreboard. The active region is programmable up to M×M.

---
 rtl/matmul_pkg.sv | 20 ++
 rtl/matmul_result_streamer.sv | 139 +++++++++++++
 tb/tb_matmul_result_streamer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for matmul and its result streamer: sizes, element and
// index types, and the streamer state encoding.
package matmul_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int M          = 32;
    localparam int ELEM_W     = 2*DATA_WIDTH + $clog2(M);
    localparam int IDX_W      = $clog2(M);
    localparam int DIM_W      = IDX_W + 1;

    typedef logic signed [ELEM_W-1:0] mat_elem;
    typedef logic [DIM_W-1:0]         dim_t;
    typedef logic [IDX_W-1:0]         idx_t;

    typedef enum logic {
        IDLE,
        STREAM
    } stream_state_e;

endpackage

// File: rtl/matmul_result_streamer.sv
// Serialises the matmul result array as a row-major valid/ready stream of
// signed elements over a programmable rows x cols active region.
module matmul_result_streamer #(
    parameter  int DATA_WIDTH = matmul_pkg::DATA_WIDTH,
    parameter  int M          = matmul_pkg::M,
    localparam int ELEM_W     = 2*DATA_WIDTH + $clog2(M),
    localparam int IW         = $clog2(M),
    localparam int DW         = IW + 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [DW-1:0]                         rows,
    input  logic [DW-1:0]                         cols,
    input  logic signed [M-1:0][M-1:0][ELEM_W-1:0] outmat,
    output logic                                  busy,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic signed [ELEM_W-1:0]              out_data,
    output logic [IW-1:0]                         out_row,
    output logic [IW-1:0]                         out_col,
    output logic                                  out_eol,
    output logic                                  out_last,
    output logic                                  done,
    output logic                                  err
);
    import matmul_pkg::*;

    typedef logic [IW-1:0] ix_t;
    typedef logic [DW-1:0] dm_t;

    localparam ix_t IX_ONE = ix_t'(1);
    localparam dm_t DM_ONE = dm_t'(1);
    localparam dm_t DM_MAX = dm_t'(M);

    stream_state_e            state_q;
    dm_t                      rows_q, cols_q, rows_src, cols_src;
    ix_t                      row_q, col_q, row_d, col_d;
    logic                     eol_q, last_q, eol_d, last_d;
    logic                     valid_q, busy_q, done_q, err_q;
    logic signed [ELEM_W-1:0] data_q, data_d;
    logic                     start_ok, handshake;

    assign start_ok  = (rows != '0) && (cols != '0) && (rows <= DM_MAX) && (cols <= DM_MAX);
    assign handshake = valid_q && out_ready;

    // Index of the element to present next; parked at (0,0) after the final
    // element so the mux never addresses outside the active region.
    always_comb begin
        rows_src = rows_q;
        cols_src = cols_q;
        row_d    = row_q;
        col_d    = col_q;
        if (state_q == IDLE) begin
            rows_src = rows;
            cols_src = cols;
            row_d    = '0;
            col_d    = '0;
        end else if (last_q) begin
            row_d = '0;
            col_d = '0;
        end else if (eol_q) begin
            row_d = row_q + IX_ONE;
            col_d = '0;
        end else begin
            col_d = col_q + IX_ONE;
        end
        eol_d  = ({1'b0, col_d} == cols_src - DM_ONE);
        last_d = eol_d && ({1'b0, row_d} == rows_src - DM_ONE);
        data_d = outmat[row_d][col_d];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rows_q  <= '0;
            cols_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            data_q  <= '0;
            eol_q   <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            rows_q  <= rows;
                            cols_q  <= cols;
                            row_q   <= row_d;
                            col_q   <= col_d;
                            data_q  <= data_d;
                            eol_q   <= eol_d;
                            last_q  <= last_d;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= STREAM;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (handshake) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            row_q  <= row_d;
                            col_q  <= col_d;
                            data_q <= data_d;
                            eol_q  <= eol_d;
                            last_q <= last_d;
                        end
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_eol   = eol_q;
    assign out_last  = last_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Self-checking bench for matmul_result_streamer: vector table of stream
// scenarios plus hand-written reset and start-during-stream sequences.
module tb_matmul_result_streamer;
    import matmul_pkg::*;

    logic                                   clk = 1'b0;
    logic                                   reset, start, out_ready;
    dim_t                                   rows, cols;
    logic signed [M-1:0][M-1:0][ELEM_W-1:0] mat;
    logic                                   busy, out_valid, out_eol, out_last, done, err;
    mat_elem                                out_data;
    idx_t                                   out_row, out_col;

    int n_vec = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        dim_t       r;
        dim_t       c;
        logic [3:0] rpat;
        int         fill;
        bit         exp_err;
    } vec_t;
    vec_t tv[6];

    matmul_result_streamer #(.DATA_WIDTH(DATA_WIDTH), .M(M)) dut (
        .clk(clk), .reset(reset), .start(start), .rows(rows), .cols(cols),
        .outmat(mat), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_eol(out_eol), .out_last(out_last), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
        end
    endtask

    function automatic logic [63:0] pack(mat_elem d, idx_t r, idx_t c, logic e, logic l);
        return {15'b0, d, r, c, e, l};
    endfunction

    function automatic logic [63:0] cur_out();
        return pack(out_data, out_row, out_col, out_eol, out_last);
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                if (mode == 0) mat[i][j] = mat_elem'(10*i + j);
                else           mat[i][j] = mat_elem'({$urandom, $urandom});
        if (mode != 0) begin
            mat[0][0]     = {1'b1, {(ELEM_W-1){1'b0}}};
            mat[M-1][M-1] = {1'b0, {(ELEM_W-1){1'b1}}};
            mat[5][7]     = '1;
        end
    endtask

    task automatic push_expected(input int r, input int c);
        for (int i = 0; i < r; i++)
            for (int j = 0; j < c; j++)
                exp_q.push_back(pack(mat[i][j], idx_t'(i), idx_t'(j),
                                     j == c-1, (j == c-1) && (i == r-1)));
    endtask

    task automatic launch(input int r, input int c);
        rows  = dim_t'(r);
        cols  = dim_t'(c);
        start = 1'b1;
        push_expected(r, c);
        step;
        start = 1'b0;
        check("launch_busy_valid", {busy, out_valid}, 2'b11);
    endtask

    // Drains the scoreboard; returns in the cycle after the final handshake.
    task automatic consume(input logic [3:0] rpat, input bit hold_start, output int cycles);
        int          k = 0;
        bit          stalled = 0;
        logic [63:0] snap = '0;
        cycles = 0;
        while (exp_q.size() > 0) begin
            if (k > 4000) begin
                n_vec++;
                n_bad++;
                $display("FAIL stream_timeout: got %0d left expected 0", exp_q.size());
                exp_q.delete();
                break;
            end
            out_ready = rpat[k % 4];
            if (hold_start) begin
                start = 1'b1;
                rows  = dim_t'(1);
                cols  = dim_t'(1);
            end
            check("valid_held", out_valid, 1'b1);
            if (stalled) check("stall_hold", cur_out(), snap);
            if (out_valid && out_ready) begin
                check("elem", cur_out(), exp_q.pop_front());
                stalled = 0;
            end else begin
                stalled = 1;
                snap    = cur_out();
            end
            step;
            k++;
            cycles++;
            if (hold_start) check("start_ignored_err", err, 1'b0);
        end
    endtask

    initial begin
        int cyc;
        tv[0] = '{dim_t'(2),  dim_t'(3),  4'b1111, 0, 1'b0};
        tv[1] = '{dim_t'(3),  dim_t'(3),  4'b1001, 0, 1'b0};
        tv[2] = '{dim_t'(32), dim_t'(32), 4'b1111, 1, 1'b0};
        tv[3] = '{dim_t'(0),  dim_t'(5),  4'b1111, 0, 1'b1};
        tv[4] = '{dim_t'(33), dim_t'(5),  4'b1111, 0, 1'b1};
        tv[5] = '{dim_t'(1),  dim_t'(32), 4'b0101, 1, 1'b0};

        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        rows = '0; cols = '0;
        fill(0);
        step;
        step;
        check("reset_data", cur_out(), 64'd0);
        check("reset_ctrl", {busy, out_valid, done, err}, 4'b0000);
        reset = 1'b0;
        step;

        for (int v = 0; v < 6; v++) begin
            fill(tv[v].fill);
            if (tv[v].exp_err) begin
                rows = tv[v].r; cols = tv[v].c; start = 1'b1;
                step;
                start = 1'b0;
                check("err_pulse", {err, busy, out_valid}, 3'b100);
                step;
                check("err_clear", {err, busy, out_valid}, 3'b000);
            end else begin
                launch(int'(tv[v].r), int'(tv[v].c));
                consume(tv[v].rpat, 1'b0, cyc);
                check("done_pulse", {done, busy, out_valid}, 3'b100);
                if (tv[v].rpat == 4'b1111)
                    check("no_bubbles", cyc, int'(tv[v].r) * int'(tv[v].c));
                step;
                check("done_one_cycle", done, 1'b0);
            end
        end

        // Reset lands on the 4th handshake of a 4x4 stream.
        fill(0);
        launch(4, 4);
        out_ready = 1'b1;
        repeat (3) step;
        check("pre_reset_elem", cur_out(), pack(mat[0][3], idx_t'(0), idx_t'(3), 1'b1, 1'b0));
        reset = 1'b1;
        step;
        reset = 1'b0;
        exp_q.delete();
        check("midreset_data", cur_out(), 64'd0);
        check("midreset_ctrl", {busy, out_valid, done, err}, 4'b0000);
        repeat (3) begin
            step;
            check("no_done_after_reset", {done, busy}, 2'b00);
        end
        launch(1, 1);
        consume(4'b1111, 1'b0, cyc);
        check("done_1x1", {done, busy, out_valid}, 3'b100);
        step;

        // start held high with 1x1 dims during a 2x2 stream, then re-used in the done cycle.
        launch(2, 2);
        consume(4'b1111, 1'b1, cyc);
        check("done_2x2", {done, busy, out_valid, err}, 4'b1000);
        rows = dim_t'(1);
        cols = dim_t'(2);
        push_expected(1, 2);
        step;
        start = 1'b0;
        check("chained_launch", {busy, out_valid}, 2'b11);
        consume(4'b1111, 1'b0, cyc);
        check("done_chained", {done, busy, out_valid}, 3'b100);
        step;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
